// File: rtl/cpu_datapath.sv
// -----------------------------------------------------------------------------
// cpu_datapath
//
// Datapath and beat sequencer for the hardwired cpu controller. Holds the
// register file R0-R3, PC, AR, IR, the C/Z flags, a 74181-style ALU subset,
// a 256x8 memory, the single internal data bus and the W1/W2/W3 beat
// generator with stop/resume.
//
// Ports
//   T3            beat clock, all state changes on its rising edge
//   CLR           synchronous reset, active-low
//   SELCTL        1: RD/RS come from SEL, 0: from IR[3:0]
//   DRW           write bus into R[RD]
//   LPC/PCADD/PCINC  PC load / relative add / increment (in that priority)
//   LAR/ARINC     AR load / increment (in that priority)
//   LIR           IR <- mem[PC]
//   LDZ/LDC       load Z / C flag from the ALU
//   CIN, M, S     ALU carry-in (inverted sense), mode, function select
//   MEMW          mem[AR] <- bus
//   MBUS/ABUS/SBUS   bus sources: memory, ALU, switches (in that priority)
//   STOP          halt after this beat's actions
//   SHORT/LONG    beat-length controls
//   SEL           console RD (SEL[3:2]) and RS (SEL[1:0])
//   SD            console switch data
//   QD            console start, releases halt
//   W             one-hot beat, W[1] is W1
//   IR, C, Z, PC, AR   register observation / controller feedback
//   DBUS          combinational internal bus value
//   HALT          sequencer halted
// -----------------------------------------------------------------------------
module cpu_datapath (
    input  logic       T3,
    input  logic       CLR,
    input  logic       SELCTL,
    input  logic       DRW,
    input  logic       LPC,
    input  logic       PCINC,
    input  logic       PCADD,
    input  logic       LAR,
    input  logic       ARINC,
    input  logic       LIR,
    input  logic       LDZ,
    input  logic       LDC,
    input  logic       CIN,
    input  logic       M,
    input  logic       MEMW,
    input  logic       ABUS,
    input  logic       SBUS,
    input  logic       MBUS,
    input  logic       STOP,
    input  logic       SHORT,
    input  logic       LONG,
    input  logic [3:0] S,
    input  logic [3:0] SEL,
    input  logic [7:0] SD,
    input  logic       QD,
    output logic [3:1] W,
    output logic [7:0] IR,
    output logic       C,
    output logic       Z,
    output logic [7:0] PC,
    output logic [7:0] AR,
    output logic [7:0] DBUS,
    output logic       HALT
);

    logic [7:0] regs_r [0:3];
    logic [7:0] mem_r  [0:255];
    logic [7:0] pc_r;
    logic [7:0] ar_r;
    logic [7:0] ir_r;
    logic       c_r;
    logic       z_r;
    logic [2:0] w_r;
    logic       halt_r;

    logic [1:0] rd_s;
    logic [1:0] rs_s;
    logic [7:0] a_s;
    logic [7:0] b_s;
    logic       cin_s;
    logic [8:0] sum_s;
    logic [7:0] f_s;
    logic       carry_s;
    logic [7:0] bus_s;
    logic [7:0] mem_ar_s;
    logic [7:0] mem_pc_s;
    logic [7:0] pc_rel_s;
    logic       run_s;

    // Next beat: W1 may repeat (SHORT), W2 may stretch into W3 (LONG).
    function automatic logic [2:0] beat_next(input logic [2:0] w,
                                             input logic short_b,
                                             input logic long_b);
        logic [2:0] nxt;
        case (w)
            3'b001:  nxt = short_b ? 3'b001 : 3'b010;
            3'b010:  nxt = long_b  ? 3'b100 : 3'b001;
            3'b100:  nxt = 3'b001;
            default: nxt = 3'b001;
        endcase
        return nxt;
    endfunction

    assign run_s    = ~halt_r;
    assign rd_s     = SELCTL ? SEL[3:2] : ir_r[3:2];
    assign rs_s     = SELCTL ? SEL[1:0] : ir_r[1:0];
    assign a_s      = regs_r[rd_s];
    assign b_s      = regs_r[rs_s];
    // The controller's CIN is active-low with respect to the adder carry.
    assign cin_s    = ~CIN;
    assign mem_ar_s = mem_r[ar_r];
    assign mem_pc_s = mem_r[pc_r];
    assign pc_rel_s = pc_r + {{4{ir_r[3]}}, ir_r[3:0]};

    // ALU: logic functions when M=1, 9-bit adder functions when M=0.
    always_comb begin
        sum_s   = 9'd0;
        f_s     = 8'h00;
        carry_s = 1'b0;
        if (M) begin
            case (S)
                4'b1011: f_s = a_s & b_s;
                4'b1110: f_s = a_s | b_s;
                4'b1010: f_s = b_s;
                4'b1111: f_s = a_s;
                4'b0000: f_s = ~a_s;
                default: f_s = 8'h00;
            endcase
            carry_s = 1'b0;
        end else begin
            case (S)
                4'b1001: sum_s = {1'b0, a_s} + {1'b0, b_s} + {8'd0, cin_s};
                4'b0110: sum_s = {1'b0, a_s} + {1'b0, ~b_s} + {8'd0, cin_s};
                4'b0000: sum_s = {1'b0, a_s} + {8'd0, cin_s};
                4'b1111: sum_s = {1'b0, a_s} + 9'h0FF + {8'd0, cin_s};
                default: sum_s = 9'd0;
            endcase
            f_s = sum_s[7:0];
            // Subtract reports borrow, so its carry is inverted.
            if (S == 4'b0110) begin
                carry_s = ~sum_s[8];
            end else begin
                carry_s = sum_s[8];
            end
        end
    end

    // Internal bus source mux, MBUS > ABUS > SBUS, idle value zero.
    always_comb begin
        bus_s = 8'h00;
        if (MBUS) begin
            bus_s = mem_ar_s;
        end else if (ABUS) begin
            bus_s = f_s;
        end else if (SBUS) begin
            bus_s = SD;
        end else begin
            bus_s = 8'h00;
        end
    end

    // Memory write port; contents deliberately survive CLR.
    always_ff @(posedge T3) begin
        if (CLR && run_s && MEMW) begin
            mem_r[ar_r] <= bus_s;
        end
    end

    // Registers, flags, PC/AR/IR and beat sequencer with halt/release.
    always_ff @(posedge T3) begin
        if (!CLR) begin
            regs_r[0] <= 8'h00;
            regs_r[1] <= 8'h00;
            regs_r[2] <= 8'h00;
            regs_r[3] <= 8'h00;
            pc_r      <= 8'h00;
            ar_r      <= 8'h00;
            ir_r      <= 8'h00;
            c_r       <= 1'b0;
            z_r       <= 1'b0;
            w_r       <= 3'b001;
            halt_r    <= 1'b1;
        end else if (halt_r) begin
            // The releasing edge only clears HALT; everything else waits.
            halt_r <= ~QD;
        end else begin
            if (DRW) begin
                regs_r[rd_s] <= bus_s;
            end
            if (LIR) begin
                ir_r <= mem_pc_s;
            end
            if (LDZ) begin
                z_r <= (f_s == 8'h00);
            end
            if (LDC) begin
                c_r <= carry_s;
            end
            if (LPC) begin
                pc_r <= bus_s;
            end else if (PCADD) begin
                pc_r <= pc_rel_s;
            end else if (PCINC) begin
                pc_r <= pc_r + 8'd1;
            end
            if (LAR) begin
                ar_r <= bus_s;
            end else if (ARINC) begin
                ar_r <= ar_r + 8'd1;
            end
            w_r    <= beat_next(w_r, SHORT, LONG);
            halt_r <= STOP;
        end
    end

    assign W    = w_r;
    assign IR   = ir_r;
    assign C    = c_r;
    assign Z    = z_r;
    assign PC   = pc_r;
    assign AR   = ar_r;
    assign HALT = halt_r;
    assign DBUS = bus_s;

endmodule

// File: tb/tb_cpu_datapath.sv
// -----------------------------------------------------------------------------
// tb_cpu_datapath
//
// Directed bench for cpu_datapath. A behavioural model (register array,
// memory array, integer beat number, plain integer ALU arithmetic) is
// advanced in step with every T3 edge; a compare process checks all DUT
// outputs against it on each falling edge. Hand-computed literals pin the
// model at the key points.
// -----------------------------------------------------------------------------
module tb_cpu_datapath;

    logic       t3;
    logic       clr, selctl, drw, lpc, pcinc, pcadd, lar, arinc, lir, ldz, ldc;
    logic       cin, m, memw, abus, sbus, mbus, stop, short_b, long_b, qd;
    logic [3:0] s, sel;
    logic [7:0] sd;
    logic [3:1] w;
    logic [7:0] ir, pc, ar, dbus;
    logic       c, z, halt;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    // Model state
    logic [7:0] m_r   [0:3];
    logic [7:0] m_mem [0:255];
    logic [7:0] m_pc, m_ar, m_ir;
    logic       m_c, m_z, m_halt;
    int         m_beat;

    cpu_datapath dut (
        .T3(t3), .CLR(clr), .SELCTL(selctl), .DRW(drw), .LPC(lpc),
        .PCINC(pcinc), .PCADD(pcadd), .LAR(lar), .ARINC(arinc), .LIR(lir),
        .LDZ(ldz), .LDC(ldc), .CIN(cin), .M(m), .MEMW(memw), .ABUS(abus),
        .SBUS(sbus), .MBUS(mbus), .STOP(stop), .SHORT(short_b), .LONG(long_b),
        .S(s), .SEL(sel), .SD(sd), .QD(qd),
        .W(w), .IR(ir), .C(c), .Z(z), .PC(pc), .AR(ar), .DBUS(dbus), .HALT(halt)
    );

    initial t3 = 1'b0;
    always #5 t3 = ~t3;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // {carry, F} from the ALU rules using plain integer arithmetic.
    function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] fs, input logic mode,
                                           input logic cinl);
        int x;
        int ai;
        int bi;
        int ci;
        ai = int'(a);
        bi = int'(b);
        ci = cinl ? 0 : 1;
        if (mode) begin
            if (fs == 4'b1011) return {1'b0, a & b};
            else if (fs == 4'b1110) return {1'b0, a | b};
            else if (fs == 4'b1010) return {1'b0, b};
            else if (fs == 4'b1111) return {1'b0, a};
            else if (fs == 4'b0000) return {1'b0, ~a};
            else return 9'd0;
        end
        if (fs == 4'b0110) begin
            x = ai - bi - (cinl ? 1 : 0);
            return {(x < 0) ? 1'b1 : 1'b0, 8'((x + 256) % 256)};
        end
        if (fs == 4'b1001)      x = ai + bi + ci;
        else if (fs == 4'b0000) x = ai + ci;
        else if (fs == 4'b1111) x = ai + 255 + ci;
        else                    x = 0;
        return {(x > 255) ? 1'b1 : 1'b0, 8'(x % 256)};
    endfunction

    function automatic logic [8:0] model_alu();
        int rd;
        int rs;
        rd = selctl ? int'(sel[3:2]) : int'(m_ir[3:2]);
        rs = selctl ? int'(sel[1:0]) : int'(m_ir[1:0]);
        return alu_ref(m_r[rd], m_r[rs], s, m, cin);
    endfunction

    function automatic logic [7:0] model_bus();
        logic [8:0] al;
        al = model_alu();
        if (mbus) return m_mem[m_ar];
        if (abus) return al[7:0];
        if (sbus) return sd;
        return 8'h00;
    endfunction

    function automatic logic [2:0] beat_onehot(input int b);
        if (b == 1) return 3'b001;
        if (b == 2) return 3'b010;
        if (b == 3) return 3'b100;
        return 3'b000;
    endfunction

    task automatic idle();
        selctl = 1'b0; drw = 1'b0; lpc = 1'b0; pcinc = 1'b0; pcadd = 1'b0;
        lar = 1'b0; arinc = 1'b0; lir = 1'b0; ldz = 1'b0; ldc = 1'b0;
        cin = 1'b0; m = 1'b0; memw = 1'b0; abus = 1'b0; sbus = 1'b0;
        mbus = 1'b0; stop = 1'b0; short_b = 1'b0; long_b = 1'b0; qd = 1'b0;
        s = 4'd0; sel = 4'd0; sd = 8'd0;
    endtask

    // One T3 edge: DUT and model both advance; returns just after the falling edge.
    task automatic tick();
        logic [8:0] al;
        logic [7:0] bus;
        logic [7:0] fetched;
        logic [7:0] old_ir;
        int rd;
        int offs;
        al      = model_alu();
        bus     = model_bus();
        fetched = m_mem[m_pc];
        old_ir  = m_ir;
        rd      = selctl ? int'(sel[3:2]) : int'(m_ir[3:2]);
        @(posedge t3);
        if (!clr) begin
            for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
            m_pc = 8'h00; m_ar = 8'h00; m_ir = 8'h00;
            m_c = 1'b0; m_z = 1'b0; m_beat = 1; m_halt = 1'b1;
        end else if (m_halt) begin
            if (qd) m_halt = 1'b0;
        end else begin
            if (memw) m_mem[m_ar] = bus;
            if (drw)  m_r[rd] = bus;
            if (lir)  m_ir = fetched;
            if (ldz)  m_z = (al[7:0] == 8'h00);
            if (ldc)  m_c = al[8];
            offs = old_ir[3] ? int'(old_ir[3:0]) - 16 : int'(old_ir[3:0]);
            if (lpc)        m_pc = bus;
            else if (pcadd) m_pc = 8'((int'(m_pc) + offs + 256) % 256);
            else if (pcinc) m_pc = 8'((int'(m_pc) + 1) % 256);
            if (lar)        m_ar = bus;
            else if (arinc) m_ar = 8'((int'(m_ar) + 1) % 256);
            if (m_beat == 1)      m_beat = short_b ? 1 : 2;
            else if (m_beat == 2) m_beat = long_b ? 3 : 1;
            else                  m_beat = 1;
            m_halt = stop;
        end
        @(negedge t3);
        #1;
    endtask

    // Console helper: write value into R[idx] through the switch path.
    task automatic con_write(input logic [1:0] idx, input logic [7:0] val);
        idle();
        selctl = 1'b1; sel = {idx, 2'b00}; sbus = 1'b1; drw = 1'b1; sd = val;
        tick();
        idle();
    endtask

    // Console helper: read R[idx] onto the bus via ALU pass-B.
    task automatic con_read(input string name, input logic [1:0] idx, input logic [7:0] exp);
        idle();
        selctl = 1'b1; sel = {2'b00, idx}; m = 1'b1; s = 4'b1010; abus = 1'b1;
        #1;
        chk(name, dbus, exp);
        idle();
    endtask

    // Compare every output against the model on each falling edge.
    always @(negedge t3) begin
        if (chk_en) begin
            chk("W",    {5'd0, w},    {5'd0, beat_onehot(m_beat)});
            chk("HALT", {7'd0, halt}, {7'd0, m_halt});
            chk("PC",   pc,   m_pc);
            chk("AR",   ar,   m_ar);
            chk("IR",   ir,   m_ir);
            chk("C",    {7'd0, c},    {7'd0, m_c});
            chk("Z",    {7'd0, z},    {7'd0, m_z});
            chk("DBUS", dbus, model_bus());
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
        m_pc = 8'h00; m_ar = 8'h00; m_ir = 8'h00;
        m_c = 1'b0; m_z = 1'b0; m_beat = 1; m_halt = 1'b1;
        idle();
        clr = 1'b0;
        tick();
        tick();
        chk_en = 1'b1;
        chk("rst_W",    {5'd0, w}, 8'h01);
        chk("rst_HALT", {7'd0, halt}, 8'h01);
        chk("rst_PC",   pc, 8'h00);
        chk("rst_IR",   ir, 8'h00);

        // Release
        clr = 1'b1; qd = 1'b1;
        tick();
        qd = 1'b0;
        chk("rel_HALT", {7'd0, halt}, 8'h00);
        chk("rel_W",    {5'd0, w}, 8'h01);
        chk("rel_PC",   pc, 8'h00);

        // Console write / read
        con_write(2'd2, 8'h5A);
        con_read("R2_read", 2'd2, 8'h5A);

        // ALU sweep over all function codes with R0=F0, R1=20
        con_write(2'd0, 8'hF0);
        con_write(2'd1, 8'h20);
        selctl = 1'b1; sel = 4'b0001; s = 4'b1001; m = 1'b0; cin = 1'b0; abus = 1'b1;
        #1;
        chk("add_cin", dbus, 8'h11);
        for (int k = 0; k < 64; k++) begin
            idle();
            selctl = 1'b1; sel = 4'b0001; abus = 1'b1; ldz = 1'b1; ldc = 1'b1;
            s = 4'(k % 16); m = (k / 16) % 2 == 1; cin = (k / 32) == 1;
            tick();
        end
        idle();

        // IR = 8'h11 via memory: mem[00] = 11, fetch with PCINC
        sbus = 1'b1; lar = 1'b1; sd = 8'h00; tick();
        idle(); sbus = 1'b1; memw = 1'b1; sd = 8'h11; tick();
        idle(); lir = 1'b1; pcinc = 1'b1; tick();
        idle();
        chk("ir11", ir, 8'h11);
        chk("pc01", pc, 8'h01);

        // ADD R0 <- R0 + R1
        s = 4'b1001; m = 1'b0; cin = 1'b1; abus = 1'b1; drw = 1'b1; ldz = 1'b1; ldc = 1'b1;
        tick();
        idle();
        chk("add_C", {7'd0, c}, 8'h01);
        chk("add_Z", {7'd0, z}, 8'h00);
        con_read("add_R0", 2'd0, 8'h10);

        // SUB R0 <- R0 - R1 with R1 = 10
        con_write(2'd1, 8'h10);
        s = 4'b0110; m = 1'b0; cin = 1'b0; abus = 1'b1; drw = 1'b1; ldz = 1'b1; ldc = 1'b1;
        tick();
        idle();
        chk("sub_Z", {7'd0, z}, 8'h01);
        chk("sub_C", {7'd0, c}, 8'h00);
        con_read("sub_R0", 2'd0, 8'h00);

        // Memory at FF and AR wrap
        sbus = 1'b1; lar = 1'b1; sd = 8'hFF; tick();
        chk("ar_ff", ar, 8'hFF);
        idle(); sbus = 1'b1; memw = 1'b1; sd = 8'h3C; tick();
        idle(); mbus = 1'b1; #1;
        chk("mem_ff", dbus, 8'h3C);
        idle(); arinc = 1'b1; tick();
        idle();
        chk("ar_wrap", ar, 8'h00);

        // LIR with PCINC in the same edge
        sbus = 1'b1; lar = 1'b1; sd = 8'h05; tick();
        idle(); sbus = 1'b1; memw = 1'b1; sd = 8'h65; tick();
        idle(); sbus = 1'b1; lpc = 1'b1; sd = 8'h05; tick();
        idle(); lir = 1'b1; pcinc = 1'b1; tick();
        idle();
        chk("lir_ir", ir, 8'h65);
        chk("lir_pc", pc, 8'h06);

        // PCADD with IR[3:0]=E (-2)
        sbus = 1'b1; lar = 1'b1; sd = 8'h30; tick();
        idle(); sbus = 1'b1; memw = 1'b1; sd = 8'h3E; tick();
        idle(); sbus = 1'b1; lpc = 1'b1; sd = 8'h30; tick();
        idle(); lir = 1'b1; tick();
        idle(); sbus = 1'b1; lpc = 1'b1; sd = 8'h10; tick();
        idle(); pcadd = 1'b1; tick();
        idle();
        chk("pcadd", pc, 8'h0E);

        // Beat lengths
        for (int i = 0; i < 4 && m_beat != 1; i++) tick();
        short_b = 1'b1; tick();
        idle();
        chk("short_W1", {5'd0, w}, 8'h01);
        tick();
        chk("W2", {5'd0, w}, 8'h02);
        long_b = 1'b1; tick();
        idle();
        chk("long_W3", {5'd0, w}, 8'h04);
        tick();
        chk("W3_W1", {5'd0, w}, 8'h01);

        // STOP at W1 with a register write, then frozen while halted
        selctl = 1'b1; sel = 4'b1100; sbus = 1'b1; drw = 1'b1; sd = 8'h77; stop = 1'b1;
        tick();
        chk("stop_HALT", {7'd0, halt}, 8'h01);
        chk("stop_W", {5'd0, w}, 8'h02);
        for (int i = 0; i < 5; i++) begin
            idle();
            selctl = 1'b1; sel = 4'b1100; sbus = 1'b1; drw = 1'b1; sd = 8'h99;
            lpc = 1'b1; long_b = 1'b1;
            tick();
            chk("frozen_W", {5'd0, w}, 8'h02);
        end
        con_read("stop_R3", 2'd3, 8'h77);

        // Release, then QD held high while running has no effect
        qd = 1'b1; tick();
        chk("rel2_HALT", {7'd0, halt}, 8'h00);
        chk("rel2_W", {5'd0, w}, 8'h02);
        long_b = 1'b1; tick();
        chk("qd_held_W3", {5'd0, w}, 8'h04);

        // Reset mid-W3 overrides STOP and QD
        clr = 1'b0; stop = 1'b1; tick();
        idle();
        clr = 1'b1;
        chk("clr_W", {5'd0, w}, 8'h01);
        chk("clr_HALT", {7'd0, halt}, 8'h01);
        chk("clr_PC", pc, 8'h00);
        chk("clr_AR", ar, 8'h00);
        for (int i = 0; i < 4; i++) begin
            con_read("clr_R", 2'(i), 8'h00);
        end
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
